// File: rtl/shared_reg_pkg.sv
// Shared types and helpers for the round-robin shared-register arbiter.
// Holds the FSM state type, index sizing and the one-hot helper.
package shared_reg_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_e;

    localparam int MAX_REQ   = 8;
    localparam int MAX_IDX_W = $clog2(MAX_REQ);

    // Widest one-hot vector; callers size-cast down to their requester count.
    function automatic logic [MAX_REQ-1:0] onehot(input logic [MAX_IDX_W-1:0] idx);
        logic [MAX_REQ-1:0] vec;
        vec      = {MAX_REQ{1'b0}};
        vec[idx] = 1'b1;
        return vec;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: scans from ptr with wrap-around and
// returns the first requesting index, optionally skipping one excluded index.
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    input  logic               exclude_en,
    input  logic [IDX_W-1:0]   exclude_idx,
    output logic               any,
    output logic [IDX_W-1:0]   idx
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);

    // Priority scan starting at ptr; the first eligible candidate is latched.
    always_comb begin : pick_scan
        logic [IDX_W-1:0] cand;
        logic             hit;
        any  = 1'b0;
        idx  = {IDX_W{1'b0}};
        cand = ptr;
        hit  = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            hit  = req[cand] && !(exclude_en && (cand == exclude_idx));
            idx  = (hit && !any) ? cand : idx;
            any  = any | hit;
            cand = (cand == LAST_IDX) ? {IDX_W{1'b0}} : cand + IDX_W'(1);
        end
    end

endmodule

// File: rtl/shared_reg_arbiter.sv
// Round-robin arbiter owning a single shared DATA_W-bit register; the granted
// requester writes it each cycle, with ownership bounded by a hold counter.
module shared_reg_arbiter
    import shared_reg_pkg::*;
#(
    parameter int NUM_REQ  = 4,
    parameter int DATA_W   = 8,
    parameter int MAX_HOLD = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_REQ-1:0]          req_i,
    input  logic [NUM_REQ*DATA_W-1:0]   data_i,
    output logic [NUM_REQ-1:0]          gnt_o,
    output logic [DATA_W-1:0]           q_o,
    output logic                        q_valid_o,
    output logic [$clog2(NUM_REQ)-1:0]  q_owner_o
);

    localparam int IDX_W  = $clog2(NUM_REQ);
    localparam int HOLD_W = $clog2(MAX_HOLD) + 1;
    localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(MAX_HOLD);
    localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);
    localparam logic [HOLD_W-1:0] HOLD_SAT  = {HOLD_W{1'b1}};
    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NUM_REQ - 1);

    arb_state_e          state_r, state_nxt_s;
    logic [NUM_REQ-1:0]  gnt_r, gnt_nxt_s;
    logic [IDX_W-1:0]    owner_r, owner_nxt_s;
    logic [IDX_W-1:0]    ptr_r, ptr_nxt_s;
    logic [HOLD_W-1:0]   hold_r, hold_nxt_s;
    logic [DATA_W-1:0]   q_r;
    logic                q_valid_r;
    logic [IDX_W-1:0]    q_owner_r;

    logic                wr_en_s;
    logic                owner_req_s;
    logic                pick_any_s;
    logic [IDX_W-1:0]    pick_idx_s;
    logic [IDX_W-1:0]    pick_next_ptr_s;
    logic [NUM_REQ-1:0]  pick_onehot_s;
    logic [DATA_W-1:0]   lane_s [NUM_REQ];

    for (genvar k = 0; k < NUM_REQ; k++) begin : g_lane
        assign lane_s[k] = data_i[k*DATA_W +: DATA_W];
    end

    // While granted, the current owner is excluded so a switch always moves on.
    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_pick (
        .req         (req_i),
        .ptr         (ptr_r),
        .exclude_en  (state_r == GRANT),
        .exclude_idx (owner_r),
        .any         (pick_any_s),
        .idx         (pick_idx_s)
    );

    assign owner_req_s     = req_i[owner_r];
    assign pick_next_ptr_s = (pick_idx_s == LAST_IDX) ? {IDX_W{1'b0}} : pick_idx_s + IDX_W'(1);
    assign pick_onehot_s   = NUM_REQ'(onehot(MAX_IDX_W'(pick_idx_s)));

    // Next-state, grant handover and hold-counter decisions.
    always_comb begin
        state_nxt_s = state_r;
        gnt_nxt_s   = gnt_r;
        owner_nxt_s = owner_r;
        ptr_nxt_s   = ptr_r;
        hold_nxt_s  = hold_r;
        wr_en_s     = 1'b0;
        case (state_r)
            IDLE: begin
                if (pick_any_s) begin
                    state_nxt_s = GRANT;
                    gnt_nxt_s   = pick_onehot_s;
                    owner_nxt_s = pick_idx_s;
                    ptr_nxt_s   = pick_next_ptr_s;
                    hold_nxt_s  = HOLD_ONE;
                end else begin
                    gnt_nxt_s   = {NUM_REQ{1'b0}};
                end
            end
            GRANT: begin
                if (owner_req_s) begin
                    wr_en_s = 1'b1;
                    if (hold_r >= HOLD_MAX) begin
                        hold_nxt_s = HOLD_ONE;
                        if (pick_any_s) begin
                            gnt_nxt_s   = pick_onehot_s;
                            owner_nxt_s = pick_idx_s;
                            ptr_nxt_s   = pick_next_ptr_s;
                        end else begin
                            gnt_nxt_s   = gnt_r;
                        end
                    end else begin
                        hold_nxt_s = (hold_r == HOLD_SAT) ? hold_r : hold_r + HOLD_W'(1);
                    end
                end else if (pick_any_s) begin
                    gnt_nxt_s   = pick_onehot_s;
                    owner_nxt_s = pick_idx_s;
                    ptr_nxt_s   = pick_next_ptr_s;
                    hold_nxt_s  = HOLD_ONE;
                end else begin
                    state_nxt_s = IDLE;
                    gnt_nxt_s   = {NUM_REQ{1'b0}};
                    hold_nxt_s  = {HOLD_W{1'b0}};
                end
            end
            default: begin
                state_nxt_s = IDLE;
                gnt_nxt_s   = {NUM_REQ{1'b0}};
                hold_nxt_s  = {HOLD_W{1'b0}};
            end
        endcase
    end

    // Arbitration state and the shared flop bank; reset wins over any write.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= IDLE;
            gnt_r     <= {NUM_REQ{1'b0}};
            owner_r   <= {IDX_W{1'b0}};
            ptr_r     <= {IDX_W{1'b0}};
            hold_r    <= {HOLD_W{1'b0}};
            q_r       <= {DATA_W{1'b0}};
            q_valid_r <= 1'b0;
            q_owner_r <= {IDX_W{1'b0}};
        end else begin
            state_r   <= state_nxt_s;
            gnt_r     <= gnt_nxt_s;
            owner_r   <= owner_nxt_s;
            ptr_r     <= ptr_nxt_s;
            hold_r    <= hold_nxt_s;
            q_valid_r <= wr_en_s;
            if (wr_en_s) begin
                q_r       <= lane_s[owner_r];
                q_owner_r <= owner_r;
            end else begin
                q_r       <= q_r;
                q_owner_r <= q_owner_r;
            end
        end
    end

    assign gnt_o     = gnt_r;
    assign q_o       = q_r;
    assign q_valid_o = q_valid_r;
    assign q_owner_o = q_owner_r;

endmodule

// File: tb/tb_shared_reg_arbiter.sv
// Self-checking bench for shared_reg_arbiter: behavioural ownership model
// checked every cycle, directed scenarios with literal expectations, random traffic.
module tb_shared_reg_arbiter;

    localparam int NR = 4;
    localparam int DW = 8;
    localparam int MH = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic [NR-1:0]     req;
    logic [NR*DW-1:0]  data;
    logic [NR-1:0]     gnt_o;
    logic [DW-1:0]     q_o;
    logic              q_valid_o;
    logic [1:0]        q_owner_o;

    int pass_cnt  = 0;
    int total_cnt = 0;
    bit chk_en    = 1'b0;

    // Behavioural model: who owns the register, how long, and what was written.
    int m_own  = -1;
    int m_ptr  = 0;
    int m_hold = 0;
    int m_q    = 0;
    int m_val  = 0;
    int m_qown = 0;
    int m_w;
    int m_k;

    shared_reg_arbiter #(.NUM_REQ(NR), .DATA_W(DW), .MAX_HOLD(MH)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_i     (req),
        .data_i    (data),
        .gnt_o     (gnt_o),
        .q_o       (q_o),
        .q_valid_o (q_valid_o),
        .q_owner_o (q_owner_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    function automatic int find_next(input logic [NR-1:0] r, input int p, input int ex);
        for (int i = 0; i < NR; i++) begin
            int c;
            c = (p + i) % NR;
            if (r[c] && c != ex) return c;
        end
        return -1;
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            m_own = -1; m_ptr = 0; m_hold = 0; m_q = 0; m_val = 0; m_qown = 0;
        end else begin
            m_val = 0;
            if (m_own < 0) begin
                m_w = find_next(req, m_ptr, -1);
                if (m_w >= 0) begin
                    m_own = m_w; m_hold = 1; m_ptr = (m_w + 1) % NR;
                end
            end else begin
                m_k = m_own;
                m_w = find_next(req, m_ptr, m_k);
                if (req[m_k]) begin
                    m_q = int'(data[m_k*DW +: DW]); m_qown = m_k; m_val = 1;
                    if (m_hold >= MH) begin
                        m_hold = 1;
                        if (m_w >= 0) begin
                            m_own = m_w; m_ptr = (m_w + 1) % NR;
                        end
                    end else begin
                        m_hold = m_hold + 1;
                    end
                end else if (m_w >= 0) begin
                    m_own = m_w; m_hold = 1; m_ptr = (m_w + 1) % NR;
                end else begin
                    m_own = -1;
                end
            end
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            check("gnt", 32'(gnt_o), (m_own < 0) ? 32'd0 : (32'd1 << m_own));
            check("q", 32'(q_o), 32'(m_q));
            check("q_valid", 32'(q_valid_o), 32'(m_val));
            check("q_owner", 32'(q_owner_o), 32'(m_qown));
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        req   = '0;
        data  = '0;
        tick();
        chk_en = 1'b1;
        tick();
        reset = 1'b0;
        check("reset_gnt", 32'(gnt_o), 32'h0);
        check("reset_q", 32'(q_o), 32'h0);
        check("reset_valid", 32'(q_valid_o), 32'h0);

        // Single requester: no release at MAX_HOLD.
        req  = 4'b0010;
        data = 32'h0000_3C00;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("single_gnt", 32'(gnt_o), 32'h2);
        end
        check("single_q", 32'(q_o), 32'h3C);
        check("single_owner", 32'(q_owner_o), 32'h1);
        check("single_valid", 32'(q_valid_o), 32'h1);

        // Owner 2 writes 0xA5, then reset mid-grant.
        data = 32'h00A5_0000;
        req  = 4'b0100;
        tick();
        tick();
        check("midgrant_q", 32'(q_o), 32'hA5);
        check("midgrant_owner", 32'(q_owner_o), 32'h2);
        do_reset();
        check("rst_mid_gnt", 32'(gnt_o), 32'h0);
        check("rst_mid_q", 32'(q_o), 32'h0);
        check("rst_mid_valid", 32'(q_valid_o), 32'h0);
        tick();
        check("regrant_2", 32'(gnt_o), 32'h4);

        // Fairness: 0,1,2,3,0 with four cycles each.
        req = 4'b0000;
        do_reset();
        req  = 4'b1111;
        data = 32'h4433_2211;
        tick();
        for (int c = 0; c < 20; c++) begin
            check("fair_gnt", 32'(gnt_o), 32'd1 << ((c / 4) % 4));
            tick();
        end

        // Release handover 0 -> 3 on a single edge.
        req = 4'b0000;
        do_reset();
        data = 32'h3300_0011;
        req  = 4'b0001;
        tick();
        tick();
        req = 4'b1000;
        tick();
        check("handover_gnt", 32'(gnt_o), 32'h8);
        check("handover_valid", 32'(q_valid_o), 32'h0);
        check("handover_q", 32'(q_o), 32'h11);

        // Wrap-around: last grant to 2, then 0101 goes to 0 before 2.
        req = 4'b0000;
        do_reset();
        req = 4'b0100;
        tick();
        req = 4'b0000;
        tick();
        check("wrap_idle", 32'(gnt_o), 32'h0);
        req = 4'b0101;
        tick();
        check("wrap_first", 32'(gnt_o), 32'h1);
        tick(); tick(); tick();
        check("wrap_hold", 32'(gnt_o), 32'h1);
        tick();
        check("wrap_second", 32'(gnt_o), 32'h4);

        // Un-granted lanes toggle; q follows lane 1 only.
        req = 4'b0000;
        do_reset();
        req = 4'b0010;
        tick();
        for (int i = 0; i < 8; i++) begin
            logic [7:0] v;
            data = $urandom;
            v    = data[15:8];
            tick();
            check("lane1_q", 32'(q_o), 32'(v));
        end

        // Random traffic against the model.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 2) == 0) req = 4'($urandom_range(0, 15));
            data  = $urandom;
            reset = ($urandom_range(0, 59) == 0);
            tick();
        end
        reset = 1'b0;
        tick();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
